// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encodings,
// requester count and the reset value of the last-owner pointer.
package arb_pkg;

  localparam int N_REQ = 4;

  // last = 3 after reset so the scan starts at requester 0
  localparam logic [1:0] LAST_RST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Requester-side bundle of the round-robin arbiter. Requesters drive the
// master modport and the arbiter drives the slave modport.
interface rr_arbiter_4_if
  import arb_pkg::*;
  ();

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [1:0]       grant_code;
  logic             grant_valid;
  logic             timeout_pls;

  modport master (
    output req,
    input  grant, grant_code, grant_valid, timeout_pls
  );

  modport slave (
    input  req,
    output grant, grant_code, grant_valid, timeout_pls
  );

endinterface

// File: rtl/rr_grant_decoder.sv
// 2-to-4 enable decoder that turns the binary owner code into a one-hot
// grant vector. The output is all zeros while the enable is low.
module rr_grant_decoder
  import arb_pkg::*;
(
  input  logic [1:0]       code,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[code] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with a hold timeout. A forced
// release masks the owner until it drops its request, so no one starves.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter_4_if.slave bus
);

  arb_state_t       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_code_q, grant_code_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_pls_q, timeout_pls_d;
  logic [N_REQ-1:0] eff_req;
  logic [N_REQ-1:0] grant_w;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  // Scans last+1, last+2, .. wrapping; descending loop lets the nearest win.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] eff,
                                         input logic [1:0]       last_owner);
    logic [1:0] idx;
    rr_pick = last_owner;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last_owner + 2'(i);
      if (eff[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    grant_code_d  = grant_code_q;
    grant_valid_d = grant_valid_q;
    timeout_pls_d = 1'b0;
    mask_d        = mask_q & bus.req;
    eff_req       = bus.req & ~mask_q;

    case (state_q)
      ST_IDLE: begin
        if (|eff_req) begin
          state_d       = ST_BUSY;
          grant_code_d  = rr_pick(eff_req, last_q);
          grant_valid_d = 1'b1;
          cnt_d         = '0;
        end
      end
      ST_BUSY: begin
        // A voluntary drop takes precedence over the timeout on the same cycle
        if (!bus.req[grant_code_q]) begin
          state_d       = ST_GAP;
          grant_valid_d = 1'b0;
          last_d        = grant_code_q;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d                = ST_GAP;
          grant_valid_d          = 1'b0;
          last_d                 = grant_code_q;
          mask_d[grant_code_q]   = 1'b1;
          timeout_pls_d          = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_q        <= LAST_RST;
      mask_q        <= '0;
      cnt_q         <= '0;
      grant_code_q  <= 2'd0;
      grant_valid_q <= 1'b0;
      timeout_pls_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      grant_code_q  <= grant_code_d;
      grant_valid_q <= grant_valid_d;
      timeout_pls_q <= timeout_pls_d;
    end
  end

  rr_grant_decoder u_decoder (
    .code   (grant_code_q),
    .en     (grant_valid_q),
    .onehot (grant_w)
  );

  assign bus.grant       = grant_w;
  assign bus.grant_code  = grant_code_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout_pls = timeout_pls_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with a short timeout: a per-cycle vector
// table for rotation/wrap, plus hand sequences for timeout, tie and reset.
module tb_rr_arbiter_4;

  localparam int TIMEOUT_CYC = 4;
  localparam int CNT_W       = 3;
  localparam int N_VEC       = 23;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] code;
    logic       valid;
    logic       pls;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  vec_t vecs [N_VEC];

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_stimulus(input logic [3:0] r);
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [3:0] eg,
                              input logic [1:0] ec, input logic ev,
                              input logic ep);
    logic [7:0] act;
    logic [7:0] exp;
    act = {bus.grant, bus.grant_code, bus.grant_valid, bus.timeout_pls};
    exp = {eg, ec, ev, ep};
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got grant=%b code=%0d valid=%b pls=%b, expected grant=%b code=%0d valid=%b pls=%b",
               name, bus.grant, bus.grant_code, bus.grant_valid, bus.timeout_pls,
               eg, ec, ev, ep);
    end
  endtask

  task automatic step_check(input string name, input logic [3:0] r,
                            input logic [3:0] eg, input logic [1:0] ec,
                            input logic ev, input logic ep);
    apply_stimulus(r);
    check_output(name, eg, ec, ev, ep);
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    rst     = 1'b1;
    bus.req = 4'b0000;

    // Rotation 0->1->2->3, each owner drops after three grant cycles, then wrap 3->0
    vecs[0]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{4'b1101, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[9]  = '{4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[10] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[11] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[12] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[13] = '{4'b1011, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[14] = '{4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[15] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[16] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[17] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[18] = '{4'b0111, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[19] = '{4'b1001, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[20] = '{4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[21] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[22] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < N_VEC; i++) begin
      step_check($sformatf("vec%0d", i), vecs[i].req, vecs[i].grant,
                 vecs[i].code, vecs[i].valid, vecs[i].pls);
    end

    // Timeout: owner 1 keeps requesting, is cut after four cycles and masked
    step_check("to_grant_c1", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step_check("to_grant_c2", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step_check("to_grant_c3", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step_check("to_grant_c4", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step_check("to_pulse",    4'b0010, 4'b0000, 2'd1, 1'b0, 1'b1);
    step_check("to_gap",      4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
    step_check("to_masked1",  4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
    step_check("to_masked2",  4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
    step_check("to_rearm",    4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    step_check("to_regrant",  4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);

    // Owner drops on the very cycle the hold limit is reached
    step_check("tie_c2",      4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step_check("tie_c3",      4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step_check("tie_c4",      4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step_check("tie_release", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    step_check("tie_gap",     4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
    step_check("tie_nomask",  4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step_check("tie_drop",    4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    step_check("tie_idle",    4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Asynchronous reset while requester 2 owns the grant
    step_check("rst_grant2",  4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step_check("rst_hold2",   4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_output("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step_check("rst_after_pick0", 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
    step_check("rst_after_hold0", 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
